scarv_cop_aes_subword_seq: RTL and testbench

Multi-cycle 32-bit SubWord / InvSubWord engine for the SCARV coprocessor AES path. It accepts a word over a valid/ready request channel and substitutes each byte through a configurable number of shared scarv_cop_aes_sbox lookups, one byte group per cycle. It returns the result on a valid/ready response channel with backpressure. It sits between the coprocessor decode/issue stage and the writeback mux, and trades sbox area for latency.

---
 rtl/scarv_cop_aes_pkg.sv | 17 +
 rtl/scarv_cop_aes_sbox.sv | 45 ++++
 rtl/scarv_cop_aes_subword_seq.sv | 124 ++++++++++++
 tb/tb_scarv_cop_aes_subword_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_aes_pkg.sv
// Shared definitions for the SCARV coprocessor AES SubWord datapath:
// sequencer state encoding, byte width and the legal sbox-parallelism check.
package scarv_cop_aes_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4);
    endfunction

endpackage

// File: rtl/scarv_cop_aes_sbox.sv
// Combinational AES forward/inverse sbox, computed as GF(2^8) inversion
// plus the (inverse) affine transform rather than as a lookup table.
module scarv_cop_aes_sbox (
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    assign out_byte = inv ? gf_inv(inv_affine(in_byte)) : affine(gf_inv(in_byte));

endmodule

// File: rtl/scarv_cop_aes_subword_seq.sv
// Multi-cycle SubWord/InvSubWord engine: substitutes BYTES_PER_CYCLE bytes of
// the captured word per cycle through shared sboxes, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// BUSY  | substituting one byte group per cycle in the operand register
// DONE  | result presented on rsp_data until rsp_ready
module scarv_cop_aes_subword_seq
    import scarv_cop_aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1,
    parameter bit ROT_EN          = 1'b0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_inv,
    input  logic        req_rot,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data
);

    generate
        if (!bpc_legal(BYTES_PER_CYCLE)) begin : g_bad_bpc
            $error("scarv_cop_aes_subword_seq: BYTES_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         WORD_BYTES = 4;
    localparam logic [1:0] LAST_CNT   = 2'(WORD_BYTES - BYTES_PER_CYCLE);
    localparam logic [1:0] CNT_STEP   = 2'(BYTES_PER_CYCLE);

    state_t                          state_q, state_d;
    logic [1:0]                      cnt_q;
    logic                            inv_q;
    logic [WORD_BYTES-1:0][BYTE_W-1:0] opr_q, opr_sub;
    logic [BYTE_W-1:0]               sbox_out [BYTES_PER_CYCLE];
    logic                            accept;
    logic [31:0]                     operand_in;

    // RotWord only applies to forward key-schedule use
    assign operand_in = (ROT_EN && req_rot && !req_inv) ? {req_data[7:0], req_data[31:8]}
                                                        : req_data;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    if (req_valid) begin
                        accept  = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush || !g_resetn) begin
            req_ready = 1'b0;
            accept    = 1'b0;
            state_d   = IDLE;
        end
    end

    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
        scarv_cop_aes_sbox u_sbox (
            .in_byte  (opr_q[cnt_q + 2'(k)]),
            .inv      (inv_q),
            .out_byte (sbox_out[k])
        );
    end

    always_comb begin
        opr_sub = opr_q;
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            opr_sub[cnt_q + 2'(k)] = sbox_out[k];
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            opr_q <= '0;
            cnt_q <= '0;
            inv_q <= 1'b0;
        end else if (accept) begin
            opr_q <= operand_in;
            cnt_q <= '0;
            inv_q <= req_inv;
        end else if (state_q == BUSY && !flush) begin
            opr_q <= opr_sub;
            cnt_q <= cnt_q + CNT_STEP;
        end
    end

    // Partial results never leave the block
    assign rsp_data = (state_q == DONE) ? opr_q : 32'h0;

endmodule

// File: tb/tb_scarv_cop_aes_subword_seq.sv
// Directed and table-model random checks of the SubWord engine at
// BYTES_PER_CYCLE = 1, 2 and 4 driven from one shared stimulus stream.
module tb_scarv_cop_aes_subword_seq;

    logic        g_clk     = 1'b0;
    logic        g_resetn  = 1'b1;
    logic        flush     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_inv   = 1'b0;
    logic        req_rot   = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req_data  = 32'h0;

    logic        req_ready_w [3];
    logic        rsp_valid_w [3];
    logic [31:0] rsp_data_w  [3];
    int          lat [3] = '{4, 2, 1};

    int n_tests = 0;
    int n_fail  = 0;
    int hs;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    scarv_cop_aes_subword_seq #(.BYTES_PER_CYCLE(1), .ROT_EN(1'b1)) u_bpc1 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .req_valid(req_valid),
        .req_ready(req_ready_w[0]), .req_inv(req_inv), .req_rot(req_rot), .req_data(req_data),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data_w[0]));

    scarv_cop_aes_subword_seq #(.BYTES_PER_CYCLE(2), .ROT_EN(1'b1)) u_bpc2 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .req_valid(req_valid),
        .req_ready(req_ready_w[1]), .req_inv(req_inv), .req_rot(req_rot), .req_data(req_data),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data_w[1]));

    scarv_cop_aes_subword_seq #(.BYTES_PER_CYCLE(4), .ROT_EN(1'b1)) u_bpc4 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .req_valid(req_valid),
        .req_ready(req_ready_w[2]), .req_inv(req_inv), .req_rot(req_rot), .req_data(req_data),
        .rsp_valid(rsp_valid_w[2]), .rsp_ready(rsp_ready), .rsp_data(rsp_data_w[2]));

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] b32(input logic b);
        return {31'b0, b};
    endfunction

    function automatic logic [7:0] m_sub(input logic [7:0] b, input logic inv);
        if (!inv) return SBOX[b];
        for (int v = 0; v < 256; v++) begin
            if (SBOX[v] == b) return 8'(v);
        end
        return 8'h00;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] d, input logic inv, input logic rot);
        logic [31:0] w;
        logic [31:0] r;
        w = (rot && !inv) ? {d[7:0], d[31:8]} : d;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m_sub(w[8*i +: 8], inv);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] d, input logic i, input logic r);
        @(negedge g_clk);
        req_valid = 1'b1;
        req_data  = d;
        req_inv   = i;
        req_rot   = r;
        #1;
        for (int k = 0; k < 3; k++) chk("issue_ready", b32(req_ready_w[k]), 32'd1);
        @(negedge g_clk);
        req_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] d, input logic i, input logic r,
                       input logic [31:0] exp);
        rsp_ready = 1'b0;
        issue(d, i, r);
        repeat (4) @(negedge g_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_vld"}, b32(rsp_valid_w[k]), 32'd1);
            chk(tag, rsp_data_w[k], exp);
        end
        rsp_ready = 1'b1;
        @(negedge g_clk);
        #1;
        for (int k = 0; k < 3; k++) chk({tag, "_drop"}, b32(rsp_valid_w[k]), 32'd0);
        rsp_ready = 1'b0;
    endtask

    task automatic rand_txn();
        logic [31:0] d, e;
        logic        iv, rt;
        logic        got   [3];
        logic        stall [3];
        logic [31:0] held  [3];
        int          cyc;
        d  = $urandom;
        iv = 1'($urandom_range(0, 1));
        rt = 1'($urandom_range(0, 1));
        e  = m_word(d, iv, rt);
        rsp_ready = 1'b0;
        issue(d, iv, rt);
        for (int k = 0; k < 3; k++) begin
            got[k] = 1'b0; stall[k] = 1'b0; held[k] = 32'h0;
        end
        cyc = 0;
        while (!(got[0] && got[1] && got[2]) && cyc < 40) begin
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            for (int k = 0; k < 3; k++) begin
                if (stall[k]) begin
                    chk("rand_hold_vld", b32(rsp_valid_w[k]), 32'd1);
                    chk("rand_hold", rsp_data_w[k], held[k]);
                end
                stall[k] = 1'b0;
                if (rsp_valid_w[k] && !got[k]) begin
                    if (rsp_ready) begin
                        chk("rand_data", rsp_data_w[k], e);
                        got[k] = 1'b1;
                    end else begin
                        stall[k] = 1'b1;
                        held[k]  = rsp_data_w[k];
                    end
                end
            end
            @(negedge g_clk);
            cyc++;
        end
        for (int k = 0; k < 3; k++) chk("rand_done", b32(got[k]), 32'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // asynchronous reset state
        #1 g_resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_vld", b32(rsp_valid_w[k]), 32'd0);
            chk("rst_data", rsp_data_w[k], 32'h0);
            chk("rst_ready", b32(req_ready_w[k]), 32'd0);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("idle_ready", b32(req_ready_w[k]), 32'd1);

        // forward word, latency per parallelism, hold under backpressure
        rsp_ready = 1'b0;
        issue(32'h03020100, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            #1;
            for (int k = 0; k < 3; k++) chk("lat_vld", b32(rsp_valid_w[k]), b32(j >= lat[k]));
            if (j < 4) @(negedge g_clk);
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge g_clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                chk("hold_vld", b32(rsp_valid_w[k]), 32'd1);
                chk("hold_data", rsp_data_w[k], 32'h7b777c63);
            end
        end
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;

        run("inv_rt", 32'h7b777c63, 1'b1, 1'b0, 32'h03020100);
        run("fwd2",   32'h10ff0053, 1'b0, 1'b0, 32'hca1663ed);
        run("inv2",   32'hca1663ed, 1'b1, 1'b0, 32'h10ff0053);
        run("rot",    32'h03020100, 1'b0, 1'b1, 32'h637b777c);
        run("rot_inv",32'h03020100, 1'b1, 1'b1, 32'hd56a0952);

        // back-to-back on the single-cycle instance
        @(negedge g_clk);
        hs = 0;
        req_valid = 1'b1; req_data = 32'h00000000; req_inv = 1'b0; req_rot = 1'b0;
        rsp_ready = 1'b1;
        #1 chk("b2b_rdy0", b32(req_ready_w[2]), 32'd1);
        @(negedge g_clk);
        #1 chk("b2b_busy0", b32(rsp_valid_w[2]), 32'd0);
        req_data = 32'hffffffff;
        @(negedge g_clk);
        #1;
        chk("b2b_vld0", b32(rsp_valid_w[2]), 32'd1);
        chk("b2b_data0", rsp_data_w[2], 32'h63636363);
        chk("b2b_rdy_done", b32(req_ready_w[2]), 32'd1);
        if (rsp_valid_w[2] && rsp_ready) hs++;
        @(negedge g_clk);
        #1 chk("b2b_busy1", b32(rsp_valid_w[2]), 32'd0);
        req_valid = 1'b0;
        @(negedge g_clk);
        #1;
        chk("b2b_vld1", b32(rsp_valid_w[2]), 32'd1);
        chk("b2b_data1", rsp_data_w[2], 32'h16161616);
        if (rsp_valid_w[2] && rsp_ready) hs++;
        repeat (8) begin
            @(negedge g_clk);
            #1 if (rsp_valid_w[2] && rsp_ready) hs++;
        end
        chk("b2b_count", 32'(hs), 32'd2);
        rsp_ready = 1'b0;

        // flush in the second BUSY cycle
        issue(32'h12345678, 1'b0, 1'b0);
        @(negedge g_clk);
        flush = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("flush_rdy", b32(req_ready_w[k]), 32'd0);
        chk("flush_vld", b32(rsp_valid_w[0]), 32'd0);
        @(negedge g_clk);
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("flush_idle_vld", b32(rsp_valid_w[k]), 32'd0);
            chk("flush_idle_rdy", b32(req_ready_w[k]), 32'd1);
        end
        run("post_flush", 32'h00000052, 1'b0, 1'b0, 32'h63636300);

        // asynchronous reset mid-operation
        issue(32'h03020100, 1'b0, 1'b0);
        @(negedge g_clk);
        #1 chk("pre_rst_vld", b32(rsp_valid_w[2]), 32'd1);
        #1 g_resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("arst_vld", b32(rsp_valid_w[k]), 32'd0);
            chk("arst_data", rsp_data_w[k], 32'h0);
            chk("arst_rdy", b32(req_ready_w[k]), 32'd0);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("arst_idle", b32(req_ready_w[k]), 32'd1);
        run("post_rst", 32'h10ff0053, 1'b0, 1'b0, 32'hca1663ed);

        // random words against the table model with random stalls
        for (int t = 0; t < 150; t++) rand_txn();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
